// File: rtl/score_digit_ctrl.sv
// BCD score keeper with one-digit-per-clock carry ripple and a slot mux for a shared glyph renderer.
// Optional FRAME_SYNC_EN: the display copy updates only during vertical blank (pixel_y >= 480).
module score_digit_ctrl #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [9:0] ORIGIN_X   = 10'd32,
  parameter logic [9:0] ORIGIN_Y   = 10'd16,
  parameter int         PITCH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  output logic                    busy,
  output logic                    inc_ack,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  output logic [3:0]              digit_value,
  output logic [9:0]              digit_x,
  output logic [9:0]              digit_y
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RIPPLE = 1'b1
  } state_t;

  localparam logic [9:0] REGION_W = 10'(NUM_DIGITS << PITCH_LOG2);

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] score_q, score_d;
  logic                    overflow_q, overflow_d;
  logic                    ack_q, ack_d;
  logic                    all_nines;
  logic [4*NUM_DIGITS-1:0] display_copy;
  logic [9:0]              rel;
  logic [2:0]              slot;
  logic                    in_region;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  // Saturating at all 9s is decided up front, so a started ripple always terminates in range.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    score_d    = score_q;
    overflow_d = overflow_q;
    ack_d      = 1'b0;

    if (clr) begin
      score_d    = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
      idx_d      = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inc) begin
            if (all_nines) begin
              overflow_d = 1'b1;
              ack_d      = 1'b1;
            end else if (score_q[3:0] == 4'd9) begin
              score_d[3:0] = 4'd0;
              idx_d        = 3'd1;
              state_d      = RIPPLE;
            end else begin
              score_d[3:0] = bcd_inc(score_q[3:0]);
              ack_d        = 1'b1;
            end
          end
        end
        RIPPLE: begin
          if (int'(idx_q) >= NUM_DIGITS) begin
            state_d = IDLE;
          end
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
              score_d[4*i +: 4] = bcd_inc(score_q[4*i +: 4]);
              if (score_q[4*i +: 4] == 4'd9) begin
                idx_d = idx_q + 3'd1;
              end else begin
                state_d = IDLE;
                ack_d   = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      score_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
    end
  end

  assign busy      = (state_q == RIPPLE);
  assign inc_ack   = ack_q;
  assign overflow  = overflow_q;
  assign score_bcd = score_q;

`ifdef FRAME_SYNC_EN
  logic [4*NUM_DIGITS-1:0] copy_q, copy_d;

  // Latch the score only in vertical blank so a frame never shows a half-updated number.
  always_comb begin
    copy_d = copy_q;
    if (clr) begin
      copy_d = '0;
    end else if (pixel_y >= 10'd480) begin
      copy_d = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      copy_q <= '0;
    end else begin
      copy_q <= copy_d;
    end
  end

  assign display_copy = copy_q;
`else
  logic unused_pixel_y;

  assign unused_pixel_y = ^pixel_y;
  assign display_copy   = score_q;
`endif

  // Slot 0 is the most significant digit; outside the row the renderer clips slot 0 itself.
  always_comb begin
    rel         = pixel_x - ORIGIN_X;
    in_region   = (pixel_x >= ORIGIN_X) && (rel < REGION_W);
    slot        = in_region ? 3'(rel >> PITCH_LOG2) : 3'd0;
    digit_value = display_copy[4*(NUM_DIGITS-1) +: 4];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == 3'(NUM_DIGITS - 1 - i)) digit_value = display_copy[4*i +: 4];
    end
    digit_x = ORIGIN_X + ({7'd0, slot} << PITCH_LOG2);
    digit_y = ORIGIN_Y;
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Randomized bench for score_digit_ctrl against an integer-arithmetic score model.
// Every negedge compares all outputs, with pixel_x drawn randomly or from slot boundaries.
module tb_score_digit_ctrl;

  localparam int N   = 4;
  localparam int MAX = 9999;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc;
  logic        clr;
  logic        busy;
  logic        inc_ack;
  logic        overflow;
  logic [15:0] score_bcd;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [3:0]  digit_value;
  logic [9:0]  digit_x;
  logic [9:0]  digit_y;

  int err_count   = 0;
  int check_count = 0;

  int m_score, m_old, m_m, m_t;
  bit m_ovf, m_busy, m_ack;

  int edges[10] = '{0, 31, 32, 47, 48, 63, 95, 96, 100, 1023};

  score_digit_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .clr         (clr),
    .busy        (busy),
    .inc_ack     (inc_ack),
    .overflow    (overflow),
    .score_bcd   (score_bcd),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .digit_value (digit_value),
    .digit_x     (digit_x),
    .digit_y     (digit_y)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    for (int k = 0; k < N; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return b;
  endfunction

  function automatic int trailing_nines(input int v);
    int t = 0;
    while (t < N && (v % 10) == 9) begin
      t++;
      v = v / 10;
    end
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Model state after the coming posedge, given the inputs presented to it.
  task automatic modelStep(input bit i_inc, input bit i_clr, input bit i_rst);
    m_ack = 1'b0;
    if (i_rst) begin
      m_score = 0;
      m_ovf   = 1'b0;
      m_busy  = 1'b0;
    end else if (i_clr) begin
      m_score = 0;
      m_ovf   = 1'b0;
      m_busy  = 1'b0;
    end else if (m_busy) begin
      m_m++;
      if (m_m <= m_t) begin
        m_score = m_old - (pow10(m_m) - 1);
      end else begin
        m_score = m_old + 1;
        m_ack   = 1'b1;
        m_busy  = 1'b0;
      end
    end else if (i_inc) begin
      if (m_score == MAX) begin
        m_ovf = 1'b1;
        m_ack = 1'b1;
      end else begin
        m_t = trailing_nines(m_score);
        if (m_t == 0) begin
          m_score = m_score + 1;
          m_ack   = 1'b1;
        end else begin
          m_old   = m_score;
          m_m     = 1;
          m_score = m_old - 9;
          m_busy  = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    int px, slot, ex_v, ex_x;
    if ($urandom_range(0, 3) == 0) px = edges[$urandom_range(0, 9)];
    else px = $urandom_range(0, 1023);
    pixel_x = 10'(px);
    pixel_y = 10'($urandom_range(0, 1023));
    #1;
    slot = (px >= 32 && px < 96) ? (px - 32) / 16 : 0;
    ex_v = (m_score / pow10(N - 1 - slot)) % 10;
    ex_x = 32 + 16 * slot;
    checkOutput("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("inc_ack", 32'(inc_ack), 32'(m_ack));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("digit_value", 32'(digit_value), 32'(ex_v));
    checkOutput("digit_x", 32'(digit_x), 32'(ex_x));
    checkOutput("digit_y", 32'(digit_y), 32'd16);
  endtask

  task automatic applyStimulus(input bit i_inc, input bit i_clr, input bit i_rst);
    inc   = i_inc;
    clr   = i_clr;
    reset = i_rst;
    modelStep(i_inc, i_clr, i_rst);
    @(negedge clk);
    checkAll();
  endtask

  task automatic countTo(input int target, input int budget);
    int guard = 0;
    while (!(m_score == target && !m_busy) && guard < budget) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_target", 32'(m_score), 32'(target));
  endtask

  initial begin
    int r;
    inc     = 1'b0;
    clr     = 1'b0;
    reset   = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    m_score = 0;
    m_old   = 0;
    m_m     = 0;
    m_t     = 0;
    m_ovf   = 1'b0;
    m_busy  = 1'b0;
    m_ack   = 1'b0;

    $display("[TB] reset");
    @(negedge clk);
    @(negedge clk);
    checkAll();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] random inc/clr/reset mix");
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 511);
      applyStimulus(1'($urandom_range(0, 1)), (r % 64) == 1, r == 0);
    end

    $display("[TB] clear during first ripple cycle from 0399");
    applyStimulus(1'b0, 1'b1, 1'b0);
    countTo(399, 3000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] count to 9999, overflow, clear");
    applyStimulus(1'b0, 1'b1, 1'b0);
    countTo(MAX, 15000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
